// File: rtl/alu_serial_add_pkg.sv
// rtl/alu_serial_add_pkg.sv - shared state encodings and sizing for the nibble-serial adder
package alu_serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_BITS = 4;

    function automatic int nib_count(input int width);
        return width / NIBBLE_BITS;
    endfunction

endpackage

// File: rtl/alu_serial_add_sum4b.sv
// rtl/alu_serial_add_sum4b.sv - 4-bit ripple-carry adder slice
module sum4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/alu_serial_add.sv
// rtl/alu_serial_add.sv - multi-cycle add/subtract, one nibble per clock through sum4b
module alu_serial_add
    import alu_serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op_sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_work;
    logic [WIDTH-1:0] b_work;
    logic [WIDTH-1:0] part_sum;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       s_nib;
    logic             s_cout;
    logic [WIDTH-1:0] final_sum;

    assign a_nib = a_work[4*idx +: 4];
    assign b_nib = b_work[4*idx +: 4];

    sum4b u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (s_cout)
    );

    // Full result as it will look once the MSB nibble lands; only used on the last edge.
    always_comb begin
        final_sum                 = part_sum;
        final_sum[WIDTH-1 -: 4]   = s_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_work   <= '0;
            b_work   <= '0;
            part_sum <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_work <= a;
                        b_work <= op_sub ? ~b : b;
                        carry  <= op_sub | ci;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    part_sum[4*idx +: 4] <= s_nib;
                    carry                <= s_cout;
                    idx                  <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= final_sum;
                        cout  <= s_cout;
                        ovf   <= (a_work[WIDTH-1] == b_work[WIDTH-1]) &&
                                 (s_nib[3] != a_work[WIDTH-1]);
                        zero  <= (final_sum == '0);
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_add.sv
// tb/tb_alu_serial_add.sv - randomized and directed self-checking bench for alu_serial_add
module tb_alu_serial_add;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         op_sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int vectors = 0;
    int miscompares = 0;

    alu_serial_add #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .op_sub (op_sub),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {cout, ovf, zero, sum}.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, mb,
                                            input logic mci, msub);
        int          sa, sb, sr;
        int unsigned ua, ub, ur;
        logic [W-1:0] s;
        logic         c, v;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'(ma);
        ub = int'(mb);
        if (msub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + int'(mci);
            c  = (ur >= 32'd65536);
            sr = sa + sb + int'(mci);
        end
        s = ur[W-1:0];
        v = (sr > 32767) || (sr < -32768);
        return {c, v, (s == '0), s};
    endfunction

    task automatic run_op(input logic [W-1:0] ia, ib, input logic ici, isub,
                          output int lat, output int bcnt, output logic [W+2:0] res);
        @(negedge clk);
        a = ia; b = ib; ci = ici; op_sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom); op_sub = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = {cout, ovf, zero, sum};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, sum, cout, ovf, zero} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy, done, sum, cout, ovf, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h000F, 16'h7FFF, 16'h0005};
        logic [W-1:0] tb [5] = '{16'h1111, 16'h0001, 16'h0000, 16'h0001, 16'h0007};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W+2:0] te [5] = '{{3'b000, 16'h2345}, {3'b101, 16'h0000},
                                 {3'b000, 16'h0010}, {3'b010, 16'h8000},
                                 {3'b000, 16'hFFFE}};
        int lat, bcnt;
        logic [W+2:0] res;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tc[i], ts[i], lat, bcnt, res);
            vectors++;
            if (res !== te[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got {c,v,z,sum}=%b_%h, want %b_%h",
                         i, res[W+2:W], res[W-1:0], te[i][W+2:W], te[i][W-1:0]);
            end
            vectors++;
            if (lat != 4 || bcnt != 4) begin
                miscompares++;
                $display("FAIL directed_latency_%0d: got done after %0d, busy %0d cycles, want 4/4",
                         i, lat, bcnt);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        logic [W+2:0] res, exp;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            exp = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, lat, bcnt, res);
            vectors++;
            if (res !== exp || lat != 4) begin
                miscompares++;
                $display("FAIL random_%0d a=%h b=%h ci=%b sub=%b: got %b_%h lat %0d, want %b_%h lat 4",
                         i, ra, rb, rc, rs, res[W+2:W], res[W-1:0], lat, exp[W+2:W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; ci = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0F00;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (sum !== 16'h0002 || lat != 4) begin
            miscompares++;
            $display("FAIL ignore_start: got sum=%h lat %0d, want 0002 lat 4", sum, lat);
        end
        start = 1'b1; a = 16'h0100; b = 16'h0200; ci = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || sum !== 16'h0002) begin
            miscompares++;
            $display("FAIL b2b_accept: got done=%b busy=%b sum=%h, want 0 1 0002", done, busy, sum);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (sum !== 16'h0300 || lat != 4) begin
            miscompares++;
            $display("FAIL b2b_result: got sum=%h lat %0d, want 0300 lat 4", sum, lat);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || sum !== 16'h0300) begin
            miscompares++;
            $display("FAIL done_pulse_hold: got done=%b sum=%h, want 0 0300", done, sum);
        end
    endtask

    task automatic test_async_reset();
        int lat, bcnt, seen;
        logic [W+2:0] res;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; ci = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout, ovf, zero} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy, done, sum, cout, ovf, zero);
        end
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat, bcnt, res);
        vectors++;
        if (res !== {3'b000, 16'h0007} || lat != 4) begin
            miscompares++;
            $display("FAIL after_reset: got %b_%h lat %0d, want 000_0007 lat 4",
                     res[W+2:W], res[W-1:0], lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
